// File: rtl/if_fetch_ctrl.sv
// Instruction-fetch controller: sequences PC requests to instruction memory,
// buffers one word across downstream stalls and handles EX branch redirects.
module if_fetch_ctrl #(
  parameter logic [31:0] RESET_PC = 32'h0000_0000,
  parameter int unsigned PC_STEP  = 4
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        freeze,
  input  logic        branch_taken,
  input  logic [31:0] branch_addr,
  output logic        imem_req,
  output logic [31:0] imem_addr,
  input  logic        imem_ready,
  input  logic [31:0] imem_rdata,
  output logic        if_valid,
  output logic [31:0] if_pc,
  output logic [31:0] if_instr,
  output logic        flush,
  output logic [15:0] fetch_count
);

  typedef enum logic [1:0] {IDLE, REQ, HOLD, DRAIN} state_e;

  localparam logic [31:0] STEP = 32'(PC_STEP);

  state_e      state_q;
  logic [31:0] pc_q;
  logic [31:0] buf_q;
  logic [31:0] pend_q;
  logic        imem_req_q;
  logic        if_valid_q;
  logic [31:0] if_pc_q;
  logic [31:0] if_instr_q;
  logic        flush_q;
  logic [15:0] fetch_count_q;
  logic [31:0] pc_next_d;

  assign pc_next_d = pc_q + STEP;

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q       <= IDLE;
      pc_q          <= RESET_PC;
      buf_q         <= 32'h0;
      pend_q        <= 32'h0;
      imem_req_q    <= 1'b0;
      if_valid_q    <= 1'b0;
      if_pc_q       <= 32'h0;
      if_instr_q    <= 32'h0;
      flush_q       <= 1'b0;
      fetch_count_q <= 16'h0;
    end else begin
      if_valid_q <= 1'b0;
      flush_q    <= branch_taken;
      case (state_q)
        IDLE: begin
          if (branch_taken) pc_q <= branch_addr;
          state_q    <= REQ;
          imem_req_q <= 1'b1;
        end
        REQ: begin
          if (branch_taken) begin
            // A redirect with the read still outstanding must wait for the
            // response before the new address can be presented.
            if (imem_ready) begin
              pc_q    <= branch_addr;
              state_q <= REQ;
            end else begin
              pend_q  <= branch_addr;
              state_q <= DRAIN;
            end
            imem_req_q <= 1'b1;
          end else if (imem_ready) begin
            if (freeze) begin
              buf_q      <= imem_rdata;
              state_q    <= HOLD;
              imem_req_q <= 1'b0;
            end else begin
              if_valid_q    <= 1'b1;
              if_instr_q    <= imem_rdata;
              if_pc_q       <= pc_next_d;
              pc_q          <= pc_next_d;
              fetch_count_q <= fetch_count_q + 16'd1;
              imem_req_q    <= 1'b1;
            end
          end else begin
            imem_req_q <= 1'b1;
          end
        end
        HOLD: begin
          if (branch_taken) begin
            pc_q       <= branch_addr;
            state_q    <= REQ;
            imem_req_q <= 1'b1;
          end else if (!freeze) begin
            if_valid_q    <= 1'b1;
            if_instr_q    <= buf_q;
            if_pc_q       <= pc_next_d;
            pc_q          <= pc_next_d;
            fetch_count_q <= fetch_count_q + 16'd1;
            state_q       <= REQ;
            imem_req_q    <= 1'b1;
          end else begin
            imem_req_q <= 1'b0;
          end
        end
        DRAIN: begin
          imem_req_q <= 1'b1;
          if (imem_ready) begin
            pc_q    <= branch_taken ? branch_addr : pend_q;
            state_q <= REQ;
          end else if (branch_taken) begin
            pend_q <= branch_addr;
          end
        end
        default: begin
          state_q    <= IDLE;
          imem_req_q <= 1'b0;
        end
      endcase
    end
  end

  assign imem_req    = imem_req_q;
  assign imem_addr   = pc_q;
  assign if_valid    = if_valid_q;
  assign if_pc       = if_pc_q;
  assign if_instr    = if_instr_q;
  assign flush       = flush_q;
  assign fetch_count = fetch_count_q;

endmodule

// File: tb/tb_if_fetch_ctrl.sv
// Directed bench for if_fetch_ctrl with a wait-state memory model that
// returns the request address as read data.
module tb_if_fetch_ctrl;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        freeze = 1'b0;
  logic        branch_taken = 1'b0;
  logic [31:0] branch_addr = 32'h0;
  logic        imem_req;
  logic [31:0] imem_addr;
  logic        imem_ready = 1'b0;
  logic [31:0] imem_rdata = 32'h0;
  logic        if_valid;
  logic [31:0] if_pc;
  logic [31:0] if_instr;
  logic        flush;
  logic [15:0] fetch_count;

  int checks = 0;
  int errors = 0;
  int mem_wait = 0;
  int wcnt = 0;
  logic mem_block = 1'b0;

  if_fetch_ctrl dut (
    .clk(clk), .rst(rst), .freeze(freeze), .branch_taken(branch_taken),
    .branch_addr(branch_addr), .imem_req(imem_req), .imem_addr(imem_addr),
    .imem_ready(imem_ready), .imem_rdata(imem_rdata), .if_valid(if_valid),
    .if_pc(if_pc), .if_instr(if_instr), .flush(flush), .fetch_count(fetch_count)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got %h exp %h", tag, got, exp);
    end else begin
      $display("ok   %s = %h", tag, got);
    end
  endtask

  task automatic mem_eval();
    imem_ready = imem_req && !mem_block && (wcnt >= mem_wait);
    imem_rdata = imem_addr;
  endtask

  task automatic tick();
    logic hs;
    logic req_prev;
    hs       = imem_req && imem_ready;
    req_prev = imem_req;
    @(posedge clk);
    #1;
    wcnt = hs ? 0 : (req_prev ? wcnt + 1 : 0);
    mem_eval();
  endtask

  task automatic do_reset();
    rst = 1'b1; freeze = 1'b0; branch_taken = 1'b0; mem_block = 1'b0; mem_wait = 0;
    tick();
    tick();
    rst = 1'b0;
  endtask

  initial begin
    // Reset state
    do_reset();
    check("rst_req",   32'(imem_req), 32'd0);
    check("rst_valid", 32'(if_valid), 32'd0);
    check("rst_pc",    if_pc, 32'd0);
    check("rst_instr", if_instr, 32'd0);
    check("rst_flush", 32'(flush), 32'd0);
    check("rst_count", 32'(fetch_count), 32'd0);

    // Zero-wait streaming
    tick();
    check("zw_req",  32'(imem_req), 32'd1);
    check("zw_addr", imem_addr, 32'd0);
    for (int i = 0; i < 7; i++) begin
      tick();
      check($sformatf("zw_valid%0d", i), 32'(if_valid), 32'd1);
      check($sformatf("zw_pc%0d", i), if_pc, 32'(4 * (i + 1)));
      check($sformatf("zw_instr%0d", i), if_instr, 32'(4 * i));
    end
    check("zw_count", 32'(fetch_count), 32'd7);

    // Two wait states
    do_reset();
    mem_wait = 2;
    tick();
    for (int k = 0; k < 3; k++) begin
      for (int j = 0; j < 3; j++) begin
        check($sformatf("ws_addr%0d_%0d", k, j), imem_addr, 32'(4 * k));
        check($sformatf("ws_valid%0d_%0d", k, j), 32'(if_valid), (j == 0 && k > 0) ? 32'd1 : 32'd0);
        tick();
      end
    end
    check("ws_valid_end", 32'(if_valid), 32'd1);
    check("ws_pc_end", if_pc, 32'd12);

    // Freeze on the response at address 8
    do_reset();
    tick();
    tick();
    tick();
    check("fz_addr", imem_addr, 32'd8);
    freeze = 1'b1;
    for (int i = 0; i < 3; i++) begin
      tick();
      check($sformatf("fz_hold_req%0d", i), 32'(imem_req), 32'd0);
      check($sformatf("fz_hold_valid%0d", i), 32'(if_valid), 32'd0);
    end
    freeze = 1'b0;
    tick();
    check("fz_valid", 32'(if_valid), 32'd1);
    check("fz_pc",    if_pc, 32'd12);
    check("fz_instr", if_instr, 32'd8);
    check("fz_req",   32'(imem_req), 32'd1);
    check("fz_addr2", imem_addr, 32'd12);
    check("fz_count", 32'(fetch_count), 32'd3);

    // Branch while 0x10 is outstanding
    do_reset();
    for (int i = 0; i < 5; i++) tick();
    check("br_addr_out", imem_addr, 32'h10);
    mem_block = 1'b1;
    mem_eval();
    branch_taken = 1'b1; branch_addr = 32'h20;
    tick();
    branch_taken = 1'b0;
    check("br_flush1", 32'(flush), 32'd1);
    check("br_drain_req", 32'(imem_req), 32'd1);
    check("br_drain_addr", imem_addr, 32'h10);
    tick();
    check("br_flush2", 32'(flush), 32'd0);
    check("br_drain_addr2", imem_addr, 32'h10);
    mem_block = 1'b0;
    mem_eval();
    tick();
    check("br_valid", 32'(if_valid), 32'd0);
    check("br_newaddr", imem_addr, 32'h20);
    check("br_count", 32'(fetch_count), 32'd4);
    tick();
    check("br_dvalid", 32'(if_valid), 32'd1);
    check("br_dpc", if_pc, 32'h24);
    check("br_dinstr", if_instr, 32'h20);

    // Branch beats freeze and ready
    do_reset();
    tick();
    branch_taken = 1'b1; branch_addr = 32'h100; freeze = 1'b1;
    tick();
    branch_taken = 1'b0; freeze = 1'b0;
    check("bf_flush", 32'(flush), 32'd1);
    check("bf_valid", 32'(if_valid), 32'd0);
    check("bf_req",   32'(imem_req), 32'd1);
    check("bf_addr",  imem_addr, 32'h100);
    tick();
    check("bf_dpc", if_pc, 32'h104);
    check("bf_count", 32'(fetch_count), 32'd1);

    // Latest target in DRAIN wins
    do_reset();
    tick();
    mem_block = 1'b1;
    mem_eval();
    branch_taken = 1'b1; branch_addr = 32'h40;
    tick();
    branch_addr = 32'h50;
    tick();
    branch_taken = 1'b0;
    check("dr_flush", 32'(flush), 32'd1);
    mem_block = 1'b0;
    mem_eval();
    tick();
    check("dr_addr", imem_addr, 32'h50);

    // Reset pulse in DRAIN
    do_reset();
    tick();
    mem_block = 1'b1;
    mem_eval();
    branch_taken = 1'b1; branch_addr = 32'h80;
    tick();
    branch_taken = 1'b0;
    rst = 1'b1;
    tick();
    rst = 1'b0; mem_block = 1'b0;
    check("rd_req0", 32'(imem_req), 32'd0);
    check("rd_flush", 32'(flush), 32'd0);
    tick();
    check("rd_req1", 32'(imem_req), 32'd1);
    check("rd_addr", imem_addr, 32'h0);
    tick();
    check("rd_pc", if_pc, 32'h4);

    // 32-bit PC wrap
    do_reset();
    tick();
    branch_taken = 1'b1; branch_addr = 32'hFFFF_FFFC;
    tick();
    branch_taken = 1'b0;
    check("wr_addr", imem_addr, 32'hFFFF_FFFC);
    tick();
    check("wr_valid", 32'(if_valid), 32'd1);
    check("wr_pc", if_pc, 32'h0);
    check("wr_instr", if_instr, 32'hFFFF_FFFC);
    check("wr_next", imem_addr, 32'h0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
